// File: rtl/uart_word_packer_if.sv
// rtl/uart_word_packer_if.sv - byte-in / word-out handshake bundle for uart_word_packer
interface uart_word_packer_if #(
    parameter int BYTE_W = 8,
    parameter int WORD_W = 16,
    parameter int CNT_W  = 3
);
    logic              uart_byte_ready;
    logic [BYTE_W-1:0] uart_byte;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              word_ready;
    logic [CNT_W-1:0]  word_count;
    logic              overflow;
    logic              clr_overflow;
    logic              resync;

    // Producer/consumer side: feeds bytes, consumes words
    modport master (
        output uart_byte_ready, uart_byte, word_ready, clr_overflow,
        input  word_valid, word, word_count, overflow, resync
    );

    // Packer side
    modport slave (
        input  uart_byte_ready, uart_byte, word_ready, clr_overflow,
        output word_valid, word, word_count, overflow, resync
    );
endinterface

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART bytes LSB-first into words, buffers them in a FIFO; optional partial-word timeout via UART_PACKER_TIMEOUT_EN
module uart_word_packer #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 8640
) (
    input logic           clk,
    input logic           rst,
    uart_word_packer_if.slave bus
);
    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic              ready_prev;
    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] partial;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] head_q;
    logic              overflow_q;

    logic              byte_stb;
    logic              last_byte;
    logic              word_done;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              timeout;
    logic [WORD_W-1:0] assembled;
    logic [WORD_W-1:0] next_head;

    // Rising-edge detect on the level-style data_ready and FIFO handshake decode
    always_comb begin
        byte_stb  = bus.uart_byte_ready & ~ready_prev;
        last_byte = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
        word_done = byte_stb & last_byte;
        full      = (count == CNT_W'(FIFO_DEPTH));
        pop       = (count != '0) & bus.word_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        push      = word_done & (~full | pop);
        drop      = word_done & full & ~pop;
    end

    // Insert the incoming byte at the current index; only used when byte_stb
    always_comb begin
        assembled = partial;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_idx == IDX_W'(k)) begin
                assembled[k*BYTE_W +: BYTE_W] = bus.uart_byte;
            end
        end
    end

    // Head word after this edge; holds its last value once the FIFO drains
    always_comb begin
        next_head = head_q;
        if (pop) begin
            if (count == CNT_W'(1)) begin
                if (push) begin
                    next_head = assembled;
                end
            end else begin
                next_head = mem[rd_ptr + PTR_W'(1)];
            end
        end else if ((count == '0) && push) begin
            next_head = assembled;
        end
    end

`ifdef UART_PACKER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr;
    logic             resync_q;

    // An accepted byte in the expiry cycle takes priority over the discard
    always_comb begin
        timeout = (byte_idx != '0) & ~byte_stb & (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
    end

    // Idle counter for a partially assembled word, plus the one-cycle resync pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr      <= '0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= timeout;
            if (byte_stb || timeout || (byte_idx == '0)) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end
        end
    end

    assign bus.resync = resync_q;
`else
    // Without the timeout a partial word waits indefinitely and resync never pulses
    always_comb begin
        timeout = 1'b0;
    end

    assign bus.resync = (TIMEOUT_CYCLES < 0);
`endif

    // Byte index, partial word and edge-detect history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_prev <= 1'b1;
            byte_idx   <= '0;
            partial    <= '0;
        end else begin
            ready_prev <= bus.uart_byte_ready;
            if (byte_stb) begin
                partial  <= assembled;
                byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
            end else if (timeout) begin
                byte_idx <= '0;
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= assembled;
        end
    end

    // FIFO pointers, occupancy, registered head word and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count + CNT_W'(push) - CNT_W'(pop);
            head_q <= next_head;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.word_valid = (count != '0);
    assign bus.word       = head_q;
    assign bus.word_count = count;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - table-driven and directed checks for uart_word_packer
module tb_uart_word_packer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_word_packer_if #(.BYTE_W(8), .WORD_W(16), .CNT_W(3)) bus ();

    uart_word_packer #(
        .BYTE_W(8),
        .BYTES_PER_WORD(2),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef UART_PACKER_TIMEOUT_EN
    localparam int HOLD_CYCLES  = 40;
    localparam int EXP_RESYNC   = 1;
`else
    localparam int HOLD_CYCLES  = 100;
    localparam int EXP_RESYNC   = 0;
`endif

    typedef enum logic [1:0] {OP_BYTE, OP_POP, OP_CLR} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  data;
        logic        valid;
        logic [15:0] word;
        logic [2:0]  count;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input op_t op, input logic [7:0] d, input logic v,
                       input logic [15:0] w, input logic [2:0] c, input logic o);
        vec_t x;
        x.op = op; x.data = d; x.valid = v; x.word = w; x.count = c; x.ovf = o;
        vecs.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [15:0] w,
                             input logic [2:0] c, input logic o);
        check({name, ".valid"},    32'(bus.word_valid), 32'(v));
        check({name, ".word"},     32'(bus.word),       32'(w));
        check({name, ".count"},    32'(bus.word_count), 32'(c));
        check({name, ".overflow"}, 32'(bus.overflow),   32'(o));
        check({name, ".resync"},   32'(bus.resync),     32'(0));
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.uart_byte       = b;
        bus.uart_byte_ready = 1'b1;
        tick();
        bus.uart_byte_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && bus.word_valid; i++) pop_one();
        check("drain.count", 32'(bus.word_count), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;

        rst                 = 1'b0;
        bus.uart_byte_ready = 1'b1;   // held high through reset: must not count as a byte
        bus.uart_byte       = 8'hEE;
        bus.word_ready      = 1'b0;
        bus.clr_overflow    = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 16'h0000, 3'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        bus.uart_byte_ready = 1'b0;
        tick();

        // Basic packing, overflow with five words, pops in order, clear, empty pop
        add(OP_BYTE, 8'hAB, 0, 16'h0000, 3'd0, 0);
        add(OP_BYTE, 8'hCD, 1, 16'hCDAB, 3'd1, 0);
        add(OP_POP,  8'h00, 0, 16'hCDAB, 3'd0, 0);
        add(OP_BYTE, 8'h01, 0, 16'hCDAB, 3'd0, 0);
        add(OP_BYTE, 8'h02, 1, 16'h0201, 3'd1, 0);
        add(OP_BYTE, 8'h03, 1, 16'h0201, 3'd1, 0);
        add(OP_BYTE, 8'h04, 1, 16'h0201, 3'd2, 0);
        add(OP_BYTE, 8'h05, 1, 16'h0201, 3'd2, 0);
        add(OP_BYTE, 8'h06, 1, 16'h0201, 3'd3, 0);
        add(OP_BYTE, 8'h07, 1, 16'h0201, 3'd3, 0);
        add(OP_BYTE, 8'h08, 1, 16'h0201, 3'd4, 0);
        add(OP_BYTE, 8'h09, 1, 16'h0201, 3'd4, 0);
        add(OP_BYTE, 8'h0A, 1, 16'h0201, 3'd4, 1);
        add(OP_POP,  8'h00, 1, 16'h0403, 3'd3, 1);
        add(OP_CLR,  8'h00, 1, 16'h0403, 3'd3, 0);
        add(OP_POP,  8'h00, 1, 16'h0605, 3'd2, 0);
        add(OP_POP,  8'h00, 1, 16'h0807, 3'd1, 0);
        add(OP_POP,  8'h00, 0, 16'h0807, 3'd0, 0);
        add(OP_POP,  8'h00, 0, 16'h0807, 3'd0, 0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_BYTE: send_byte(vecs[i].data);
                OP_POP:  pop_one();
                default: begin
                    bus.clr_overflow = 1'b1;
                    tick();
                    bus.clr_overflow = 1'b0;
                end
            endcase
            check_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].word,
                      vecs[i].count, vecs[i].ovf);
        end

        // Full FIFO with a pop on the completing edge: push succeeds, no overflow
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        bus.uart_byte       = 8'h0A;
        bus.uart_byte_ready = 1'b1;
        bus.word_ready      = 1'b1;
        tick();
        bus.uart_byte_ready = 1'b0;
        bus.word_ready      = 1'b0;
        check_out("full_pop_push", 1'b1, 16'h0403, 3'd4, 1'b0);
        begin
            logic [15:0] exp_words [4];
            exp_words[0] = 16'h0403; exp_words[1] = 16'h0605;
            exp_words[2] = 16'h0807; exp_words[3] = 16'h0A09;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("drain_order%0d", i), 32'(bus.word), 32'(exp_words[i]));
                pop_one();
            end
        end
        check("after_order.count", 32'(bus.word_count), 32'(0));

        // Drop and clr_overflow on the same edge: set wins
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h10 + 8'(i));
            send_byte(8'h20 + 8'(i));
        end
        send_byte(8'h5A);
        bus.uart_byte        = 8'hA5;
        bus.uart_byte_ready  = 1'b1;
        bus.clr_overflow     = 1'b1;
        tick();
        bus.uart_byte_ready  = 1'b0;
        bus.clr_overflow     = 1'b0;
        check_out("drop_vs_clr", 1'b1, 16'h2010, 3'd4, 1'b1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("clr_alone.overflow", 32'(bus.overflow), 32'(0));
        drain();

        // Level held high after one byte: exactly one byte accepted
        bus.uart_byte       = 8'h77;
        bus.uart_byte_ready = 1'b1;
        for (int i = 0; i < HOLD_CYCLES; i++) tick();
        bus.uart_byte_ready = 1'b0;
        check("held.valid", 32'(bus.word_valid), 32'(0));
        tick();
        bus.uart_byte       = 8'h88;
        bus.uart_byte_ready = 1'b1;
        tick();
        bus.uart_byte_ready = 1'b0;
        check_out("held_next", 1'b1, 16'h8877, 3'd1, 1'b0);
        tick();
        drain();

        // Long idle with a partial word
        send_byte(8'h11);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.resync) pulses++;
        end
        check("resync_pulses", 32'(pulses), 32'(EXP_RESYNC));
        send_byte(8'h22);
`ifdef UART_PACKER_TIMEOUT_EN
        check("timeout.valid_mid", 32'(bus.word_valid), 32'(0));
        send_byte(8'h33);
        check_out("timeout_word", 1'b1, 16'h3322, 3'd1, 1'b0);
`else
        check_out("no_timeout_word", 1'b1, 16'h2211, 3'd1, 1'b0);
`endif
        drain();

        // Asynchronous reset with a stored word and a partial byte
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h99);
        check("pre_reset.word", 32'(bus.word), 32'(16'h1234));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 16'h0000, 3'd0, 1'b0);
        #1;
        rst = 1'b1;
        tick();
        send_byte(8'h55);
        send_byte(8'h66);
        check_out("post_reset", 1'b1, 16'h6655, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
